// File: rtl/dac_playout_buffer_if.sv
// Sample bus between the USB interface side and the DAC playout buffer.
// The master drives samples in and receives paced samples and status out.
interface dac_playout_buffer_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic [13:0]         in_data_i;
  logic                in_rdy_i;
  logic [13:0]         out_data_o;
  logic                out_rdy_o;
  logic [DEPTH_LOG2:0] level_o;
  logic                led_overflow_o;
  logic                led_underrun_o;

  modport master (
    output in_data_i, in_rdy_i,
    input  out_data_o, out_rdy_o, level_o, led_overflow_o, led_underrun_o
  );

  modport slave (
    input  in_data_i, in_rdy_i,
    output out_data_o, out_rdy_o, level_o, led_overflow_o, led_underrun_o
  );
endinterface

// File: rtl/dac_playout_buffer.sv
// Elastic FIFO releasing 14-bit DAC samples at a fixed counter-derived rate.
// DAC_PLAYOUT_REPEAT_EN: on underrun repeat the last sample instead of re-priming.
module dac_playout_buffer #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned DIV         = 250,
  parameter int unsigned PRIME_LEVEL = 8,
  parameter int unsigned LEDCNT_MAX  = 7200000
) (
  input logic                 clk_i,
  input logic                 reset_ni,
  dac_playout_buffer_if.slave bus
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W  = DEPTH_LOG2 + 1;
  localparam int unsigned CNT_W  = $clog2(DIV);
  localparam int unsigned LED_W  = 26;
  localparam int unsigned DATA_W = 14;

  typedef enum logic {PRIME, PLAY} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DATA_W-1:0]       out_data_q;
  logic                    out_rdy_q;
  logic [LED_W-1:0]        ovf_cnt_q, ovf_cnt_d;
  logic [LED_W-1:0]        udr_cnt_q, udr_cnt_d;
  logic                    led_ovf_q, led_udr_q;

  logic tick, empty, full, pop, underrun, wr_en, overflow;

  // Event decode from registered state only; the empty test uses the registered level.
  always_comb begin
    tick     = (state_q == PLAY) && (cnt_q == CNT_W'(DIV - 1));
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    pop      = tick && !empty;
    underrun = tick && empty;
    wr_en    = bus.in_rdy_i && (!full || pop);
    overflow = bus.in_rdy_i && !wr_en;
  end

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // LED stretchers reload on every new event and count down to zero.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    udr_cnt_d = udr_cnt_q;
    if (overflow)             ovf_cnt_d = LED_W'(LEDCNT_MAX);
    else if (ovf_cnt_q != '0) ovf_cnt_d = ovf_cnt_q - LED_W'(1);
    if (underrun)             udr_cnt_d = LED_W'(LEDCNT_MAX);
    else if (udr_cnt_q != '0) udr_cnt_d = udr_cnt_q - LED_W'(1);
  end

  // Sample storage carries no reset; stale entries are unreachable via the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= bus.in_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= PRIME;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      out_rdy_q  <= 1'b0;
      ovf_cnt_q  <= '0;
      udr_cnt_q  <= '0;
      led_ovf_q  <= 1'b0;
      led_udr_q  <= 1'b0;
    end else begin
      level_q   <= level_d;
      ovf_cnt_q <= ovf_cnt_d;
      udr_cnt_q <= udr_cnt_d;
      led_ovf_q <= (ovf_cnt_d != '0);
      led_udr_q <= (udr_cnt_d != '0);
      if (wr_en) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + DEPTH_LOG2'(1);
        out_data_q <= mem[rd_ptr_q];
      end
`ifdef DAC_PLAYOUT_REPEAT_EN
      out_rdy_q <= tick;
`else
      out_rdy_q <= pop;
`endif
      case (state_q)
        PRIME: begin
          cnt_q <= '0;
          if (level_q >= LVL_W'(PRIME_LEVEL)) state_q <= PLAY;
        end
        PLAY: begin
          cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
`ifndef DAC_PLAYOUT_REPEAT_EN
          if (underrun) state_q <= PRIME;
`endif
        end
      endcase
    end
  end

  assign bus.out_data_o     = out_data_q;
  assign bus.out_rdy_o      = out_rdy_q;
  assign bus.level_o        = level_q;
  assign bus.led_overflow_o = led_ovf_q;
  assign bus.led_underrun_o = led_udr_q;

endmodule

// File: tb/tb_dac_playout_buffer.sv
// Directed bench for dac_playout_buffer (DEPTH_LOG2=2, DIV=8, PRIME_LEVEL=2, LEDCNT_MAX=20).
// Expectations follow DAC_PLAYOUT_REPEAT_EN when it is defined for the build.
module tb_dac_playout_buffer;

`ifdef DAC_PLAYOUT_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dac_playout_buffer_if #(.DEPTH_LOG2(2)) bus ();

  dac_playout_buffer #(
    .DEPTH_LOG2 (2),
    .DIV        (8),
    .PRIME_LEVEL(2),
    .LEDCNT_MAX (20)
  ) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance negedge by negedge until out_rdy_o is seen; n = -1 if never within the bound.
  task automatic wait_rdy(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.out_rdy_o === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_rdy_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int led_cnt;
    int pulses;
    int early;
    int pops [$];

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.in_rdy_i  = 1'b0;
    bus.in_data_i = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_data", 32'(bus.out_data_o), 32'h0);
    check("rst_out_rdy", 32'(bus.out_rdy_o), 32'h0);
    check("rst_level", 32'(bus.level_o), 32'h0);
    check("rst_led_ovf", 32'(bus.led_overflow_o), 32'h0);
    check("rst_led_udr", 32'(bus.led_underrun_o), 32'h0);
    rst_n = 1'b1;

    // Two writes prime the buffer, then paced playout
    bus.in_rdy_i  = 1'b1;
    bus.in_data_i = 14'h1234;
    @(negedge clk);
    check("s2_level1", 32'(bus.level_o), 32'd1);
    bus.in_data_i = 14'h0ABC;
    @(negedge clk);
    bus.in_rdy_i = 1'b0;
    check("s2_level2", 32'(bus.level_o), 32'd2);
    wait_rdy(n);
    check("s2_first_latency", 32'(n), 32'd9);
    check("s2_first_data", 32'(bus.out_data_o), 32'h1234);
    check("s2_level_after_pop1", 32'(bus.level_o), 32'd1);
    wait_rdy(n);
    check("s2_second_period", 32'(n), 32'd8);
    check("s2_second_data", 32'(bus.out_data_o), 32'h0ABC);
    check("s2_level_after_pop2", 32'(bus.level_o), 32'd0);

    // Drain into underrun
    early = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (bus.out_rdy_o !== 1'b0) early++;
    end
    check("s5_no_early_pulse", 32'(early), 32'd0);
    @(negedge clk);
    check("s5_underrun_rdy", 32'(bus.out_rdy_o), REPEAT ? 32'd1 : 32'd0);
    check("s5_underrun_data", 32'(bus.out_data_o), 32'h0ABC);
    check("s5_underrun_led", 32'(bus.led_underrun_o), 32'd1);
    led_cnt = 0;
    pulses  = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.led_underrun_o === 1'b1) led_cnt++;
      if (bus.out_rdy_o === 1'b1) pulses++;
      @(negedge clk);
    end
    check("s5_led_udr_cycles", 32'(led_cnt), REPEAT ? 32'd25 : 32'd20);
    check("s5_pulses", 32'(pulses), REPEAT ? 32'd4 : 32'd0);
    check("s5_data_held", 32'(bus.out_data_o), 32'h0ABC);

    // Five back-to-back writes into a 4-entry FIFO
    do_reset();
    bus.in_rdy_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.in_data_i = 14'(i);
      @(negedge clk);
      check($sformatf("s3_level_w%0d", i), 32'(bus.level_o), (i < 4) ? 32'(i) : 32'd4);
      check($sformatf("s3_led_ovf_w%0d", i), 32'(bus.led_overflow_o), (i == 5) ? 32'd1 : 32'd0);
    end
    bus.in_rdy_i = 1'b0;
    led_cnt = 0;
    for (int i = 0; i < 31; i++) begin
      if (bus.led_overflow_o === 1'b1) led_cnt++;
      if (bus.out_rdy_o === 1'b1) pops.push_back(int'(bus.out_data_o));
      @(negedge clk);
    end
    check("s3_led_ovf_cycles", 32'(led_cnt), 32'd20);
    check("s3_pop_count", 32'(pops.size()), 32'd4);
    for (int k = 0; k < pops.size(); k++)
      check($sformatf("s3_pop%0d", k), 32'(pops[k]), 32'(k + 1));
    check("s3_level_drained", 32'(bus.level_o), 32'd0);

    // Write coinciding with a pop while full
    do_reset();
    bus.in_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data_i = 14'(32'h11 + i);
      @(negedge clk);
    end
    bus.in_rdy_i = 1'b0;
    check("s4_full", 32'(bus.level_o), 32'd4);
    repeat (6) @(negedge clk);
    bus.in_rdy_i  = 1'b1;
    bus.in_data_i = 14'h0015;
    @(negedge clk);
    bus.in_rdy_i = 1'b0;
    check("s4_pop_rdy", 32'(bus.out_rdy_o), 32'd1);
    check("s4_pop_data", 32'(bus.out_data_o), 32'h11);
    check("s4_level_kept", 32'(bus.level_o), 32'd4);
    check("s4_no_ovf_led", 32'(bus.led_overflow_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      wait_rdy(n);
      check($sformatf("s4_period%0d", k), 32'(n), 32'd8);
      check($sformatf("s4_data%0d", k), 32'(bus.out_data_o), 32'h12 + 32'(k));
    end
    check("s4_level_drained", 32'(bus.level_o), 32'd0);

    // Write in the same cycle as an empty tick
    repeat (7) @(negedge clk);
    bus.in_rdy_i  = 1'b1;
    bus.in_data_i = 14'h0777;
    @(negedge clk);
    bus.in_rdy_i = 1'b0;
    check("s6_led_udr", 32'(bus.led_underrun_o), 32'd1);
    check("s6_level", 32'(bus.level_o), 32'd1);
    check("s6_rdy", 32'(bus.out_rdy_o), REPEAT ? 32'd1 : 32'd0);
    check("s6_data", 32'(bus.out_data_o), 32'h0015);

    // Asynchronous reset mid-cycle during PLAY with three entries queued
    bus.in_rdy_i  = 1'b1;
    bus.in_data_i = 14'h0101;
    @(negedge clk);
    bus.in_data_i = 14'h0102;
    @(negedge clk);
    bus.in_rdy_i = 1'b0;
    check("s1_level_pre", 32'(bus.level_o), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("s1_async_data", 32'(bus.out_data_o), 32'h0);
    check("s1_async_rdy", 32'(bus.out_rdy_o), 32'h0);
    check("s1_async_level", 32'(bus.level_o), 32'h0);
    check("s1_async_led_ovf", 32'(bus.led_overflow_o), 32'h0);
    check("s1_async_led_udr", 32'(bus.led_underrun_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_rdy_i  = 1'b1;
    bus.in_data_i = 14'h3FFF;
    @(negedge clk);
    bus.in_rdy_i = 1'b0;
    check("s1_single_write_level", 32'(bus.level_o), 32'd1);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_rdy_o !== 1'b0) pulses++;
    end
    check("s1_no_playout", 32'(pulses), 32'd0);
    check("s1_level_held", 32'(bus.level_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
